// File: rtl/uart_tx_fifo_if.sv
// Send-port bundle between the core (master) and the UART transmit FIFO (slave).
// Carries the byte/strobe pair plus the line and fill-state outputs.
interface uart_tx_fifo_if #(
   parameter int aw = 3
);
   logic [7:0]  denv;
   logic        wr;
   logic        tx;
   logic        busy;
   logic        full;
   logic        empty;
   logic [aw:0] count;
   logic        ovf;

   modport master (
      output denv, wr,
      input  tx, busy, full, empty, count, ovf
   );

   modport slave (
      input  denv, wr,
      output tx, busy, full, empty, count, ovf
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a 2^aw-entry byte FIFO.
// All outputs are registered; a pop loads the shift register and starts a frame.
module uart_tx_fifo #(
   parameter int clk_freq = 50000000,
   parameter int baud     = 115200,
   parameter int aw       = 3
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_fifo_if.slave  bus
);
   localparam int div   = clk_freq / baud;
   localparam int depth = 1 << aw;
   localparam int cw    = (div > 1) ? $clog2(div) : 1;
   localparam logic [cw-1:0] div_last  = cw'(div - 1);
   localparam logic [aw:0]   depth_cnt = (aw + 1)'(depth);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem_q [depth];
   logic [aw-1:0] wr_ptr_q, wr_ptr_d;
   logic [aw-1:0] rd_ptr_q, rd_ptr_d;
   logic [aw:0]   count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          ovf_q, ovf_d;
   state_t        state_q, state_d;
   logic [cw-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          push, pop, bit_end;

   always_comb begin
      push    = bus.wr && !full_q;
      bit_end = (baud_q == div_last);
      // A pop happens from IDLE, or straight out of the last STOP cycle for gapless frames
      pop     = !empty_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

      wr_ptr_d = wr_ptr_q + aw'(push);
      rd_ptr_d = rd_ptr_q + aw'(pop);
      count_d  = count_q + (aw + 1)'(push) - (aw + 1)'(pop);
      full_d   = (count_d == depth_cnt);
      empty_d  = (count_d == '0);
      ovf_d    = ovf_q | (bus.wr & full_q);

      state_d = state_q;
      baud_d  = baud_q + cw'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (pop) begin
               state_d = START;
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = 3'(bit_q + 3'd1);
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (pop) begin
                  state_d = START;
                  shift_d = mem_q[rd_ptr_q];
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end

   // Storage has no reset; only the pointers define which entries are valid
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= bus.denv;
      end
   end

   assign bus.tx    = tx_q;
   assign bus.busy  = busy_q;
   assign bus.full  = full_q;
   assign bus.empty = empty_q;
   assign bus.count = count_q;
   assign bus.ovf   = ovf_q;
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit stage sitting directly downstream of the system's `denv`/`wr` send port: it buffers bytes written by the core in an 8-entry FIFO and serializes them onto a UART line as 8N1 frames. It decouples the core, which writes bytes in single clock cycles, from the slow serial line, and reports fill state so software or the I/O decoder can throttle writes.

## Interface
- `clk_freq`, 50000000, system clock frequency in Hz
- `baud`, 115200, line rate in bit/s; bit period `div = clk_freq / baud` (integer, truncated, must be ≥ 2)
- `aw`, 3, FIFO address width; depth = 2^aw entries
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `denv`  in  8  byte to transmit
- `wr`  in  1  write strobe, one byte per cycle high
- `tx`  out  1  serial line, idle high
- `busy`  out  1  high while a frame is on the line
- `full`  out  1  FIFO holds 2^aw bytes
- `empty`  out  1  FIFO holds 0 bytes
- `count`  out  aw+1  current FIFO occupancy
- `ovf`  out  1  sticky: a write was dropped because the FIFO was full

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `count`=0, `ovf`=0; FIFO pointers = 0; FSM = IDLE; baud counter = 0.
- Write: at an edge with `wr`=1 and `full`=0 (pre-edge value), `denv` is stored at the write pointer, and the write pointer advances mod 2^aw. With `full`=1, the byte is discarded and `ovf` is set; the FIFO is unchanged.
- `ovf` clears only on `rst`.
- Pop: in IDLE with `empty`=0 (pre-edge), the FSM loads the head byte into the shift register, advances the read pointer, and enters START.
- Simultaneous write and pop: `count` is unchanged and both pointers advance. A write while full is dropped even if a pop happens on the same edge.
- `full`/`empty`/`count` are registered and consistent with the pointers after every edge.
- FSM states:
  - IDLE: `tx`=1, `busy`=0.
  - START: `tx`=0 for `div` cycles.
  - DATA: 8 bits, LSB first, each for `div` cycles; a 3-bit bit index goes 0..7.
  - STOP: `tx`=1 for `div` cycles. At the end of STOP, if `empty`=0, pop directly into START (no idle cycle); otherwise go to IDLE.
- `busy`=1 in START, DATA and STOP.
- Baud counter: counts 0..div-1 and restarts at 0 on every state or bit change. A bit boundary occurs when count = div-1.

## Timing
- Write at edge N into an empty FIFO with the FSM in IDLE:
  - `count`=1 and `empty`=0 after edge N.
  - Pop at edge N+1: `tx` falls and `busy` rises after edge N+1, and `count` returns to 0.
- Frame length is exactly 10·div cycles: start edge to the end of stop.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit. `tx` is continuous with no extra high cycles.
- Data bit k is driven from cycle (k+1)·div to (k+2)·div-1, counted from the start-bit edge.
- `rst` mid-frame: after the reset edge, `tx`=1 and the FIFO is flushed (count 0). A partially sent frame is truncated; no completion of it is guaranteed.
- Write throughput into the FIFO is 1 byte/cycle until `full`.
- There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `clk_freq`=1000, `baud`=100 (div=10), `aw`=3.
- Reset: hold `rst` for 3 cycles. After it deasserts, `tx`=1, `empty`=1, `count`=0, `busy`=0, `ovf`=0, and `tx` stays high for 50 cycles.
- Single byte: write 0xA5 at edge N.
  - `tx` falls after N+1.
  - Sampling at mid-bit (start edge + 5 + 10k) yields 0,1,0,1,0,0,1,0,1,1: start, LSB-first 0xA5, stop.
  - `busy` drops after 100 cycles and `empty`=1.
- Burst: write 0x11, 0x22, 0x33 on consecutive edges.
  - `count` peaks at 2 (the first byte is popped at the next edge).
  - Three frames go out back to back, 300 cycles total, with no idle gap. The decoded bytes are in order.
- Overflow: while the first frame sends, write 10 bytes on consecutive cycles (FIFO initially empty, FSM busy).
  - `full` rises after the 8th write and `count`=8.
  - The 9th and 10th writes are dropped and `ovf`=1.
  - Exactly 9 frames are transmitted: the one in flight plus 8 buffered.
- Write on pop edge when full: with `full`=1, raise `wr` on the same edge as the STOP→START pop. The byte is dropped, `ovf`=1, and `count` goes 8→7.
- Reset mid-frame: assert `rst` during DATA bit 3. After the edge `tx`=1, `count`=0, `busy`=0, and no further frames are transmitted.
